jtsdram_bank_chk: RTL

// Per-bank read checker between the test sequencer and the SDRAM controller's bank read port.
// On each start pulse it latches a 5-bit key and sweeps NREAD word addresses from a key-derived base.
// It compares each returned word against the fixed address pattern written by the programmer stage.
// It counts mismatches and timeouts, then raises done. One instance per bank, BA = 0..3.

---
 rtl/jtsdram_bank_chk.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/jtsdram_bank_chk.sv
// Per-bank SDRAM read checker: sweeps NREAD addresses from a key-derived base,
// compares each returned word against the address pattern and tallies errors.
module jtsdram_bank_chk #(
    parameter int unsigned     BA    = 0,
    parameter int unsigned     AW    = 22,
    parameter longint unsigned NREAD = 256,
    parameter int unsigned     TOUT  = 1023
) (
    input  logic          rst,
    input  logic          clk,
    input  logic [4:0]    key,
    input  logic          start,
    output logic          done,
    output logic          ba_rd,
    output logic [AW-1:0] ba_addr,
    input  logic          ba_ack,
    input  logic          ba_rdy,
    input  logic [15:0]   ba_dout,
    output logic [15:0]   err_cnt,
    output logic          err_flag,
    output logic [AW-1:0] err_addr
);

    localparam int unsigned TW    = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
    localparam logic [AW:0] NLAST = (AW + 1)'(NREAD);
    localparam logic [1:0]  BA2   = 2'(BA);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]    st_q, st_d;
    logic [4:0]    key_q, key_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   n_q, n_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          done_q, done_d;
    logic          rd_q, rd_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          flag_q, flag_d;
    logic [AW-1:0] eaddr_q, eaddr_d;

    logic [AW-1:0] stride;
    logic [15:0]   hi16;
    logic [15:0]   exp_data;
    logic          busy;
    logic          hit;
    logic          tout;
    logic          bad;

    assign stride   = {{(AW - 6){1'b0}}, key_q, 1'b1};
    assign hi16     = 16'(addr_q[AW-1:16]);
    assign exp_data = addr_q[15:0] ^ hi16 ^ {BA2, 14'b0};

    // An ack+rdy cycle in REQ counts as ack followed immediately by rdy.
    assign busy = (st_q == StReq) || (st_q == StWait);
    assign hit  = ba_rdy && ((st_q == StWait) || (st_q == StReq && ba_ack));
    assign tout = busy && !hit && (tmr_q == TW'(TOUT));
    assign bad  = (hit && (ba_dout != exp_data)) || tout;

    always_comb begin
        st_d    = st_q;
        key_d   = key_q;
        addr_d  = addr_q;
        n_d     = n_q;
        tmr_d   = tmr_q;
        done_d  = done_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        eaddr_d = eaddr_q;

        case (st_q)
            StIdle: begin
                if (start) begin
                    key_d  = key;
                    addr_d = {key, {(AW - 5){1'b0}}};
                    n_d    = '0;
                    tmr_d  = '0;
                    done_d = 1'b0;
                    rd_d   = 1'b1;
                    st_d   = StReq;
                end
            end
            StReq, StWait: begin
                tmr_d = tmr_q + 1'b1;
                if (st_q == StReq && ba_ack) begin
                    rd_d = 1'b0;
                    st_d = StWait;
                end
                if (hit) begin
                    n_d = n_q + 1'b1;
                    if (n_d == NLAST) begin
                        rd_d = 1'b0;
                        st_d = StDone;
                    end else begin
                        addr_d = addr_q + stride;
                        tmr_d  = '0;
                        rd_d   = 1'b1;
                        st_d   = StReq;
                    end
                end else if (tout) begin
                    rd_d = 1'b0;
                    st_d = StDone;
                end
            end
            StDone: begin
                done_d = 1'b1;
                st_d   = StIdle;
            end
            default: st_d = StIdle;
        endcase

        if (bad) begin
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            flag_d = 1'b1;
            // Only the first error since reset is recorded.
            if (!flag_q) eaddr_d = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= StIdle;
            key_q   <= '0;
            addr_q  <= '0;
            n_q     <= '0;
            tmr_q   <= '0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            eaddr_q <= '0;
        end else begin
            st_q    <= st_d;
            key_q   <= key_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            eaddr_q <= eaddr_d;
        end
    end

    assign done     = done_q & ~start;
    assign ba_rd    = rd_q;
    assign ba_addr  = addr_q;
    assign err_cnt  = cnt_q;
    assign err_flag = flag_q;
    assign err_addr = eaddr_q;

endmodule
